// File: rtl/reg_write_pkg.sv
//------------------------------------------------------------------------------
// reg_write_pkg
// Shared sizing constants and address type for the writeback scoreboard.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package reg_write_pkg;
  localparam int ADDR_W_DEFAULT   = 5;
  localparam int NREG_DEFAULT     = 2 ** ADDR_W_DEFAULT;
  localparam int ZERO_REG_DEFAULT = 31;

  typedef logic [ADDR_W_DEFAULT-1:0] addr_t;
endpackage

`default_nettype wire

// File: rtl/reg_write_scoreboard_decoder_n.sv
//------------------------------------------------------------------------------
// decoder_n
// Enabled ADDR_W-to-2**ADDR_W one-hot decoder.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module decoder_n #(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0]      addr_in,
  input  logic                   enable,
  output logic [(2**ADDR_W)-1:0] onehot_out
);
  for (genvar i = 0; i < 2 ** ADDR_W; i++) begin : g_bit
    assign onehot_out[i] = enable & (addr_in == ADDR_W'(i));
  end
endmodule

`default_nettype wire

// File: rtl/reg_write_scoreboard.sv
//------------------------------------------------------------------------------
// reg_write_scoreboard
// Writeback one-hot enable decode plus pending-write busy mask for hazard checks.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module reg_write_scoreboard
  import reg_write_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEFAULT,
  parameter int ZERO_REG = ZERO_REG_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   issue_valid,
  input  logic [ADDR_W-1:0]      issue_addr,
  output logic                   issue_ready,
  input  logic                   wb_valid,
  input  logic [ADDR_W-1:0]      wb_addr,
  input  logic [ADDR_W-1:0]      rd_addr_a,
  input  logic [ADDR_W-1:0]      rd_addr_b,
  output logic                   hazard_a,
  output logic                   hazard_b,
  output logic [(2**ADDR_W)-1:0] we_onehot,
  output logic [(2**ADDR_W)-1:0] busy,
  output logic                   wb_orphan
);
  localparam int                NREG        = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] C_ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] r_we_onehot;
  logic            r_wb_orphan;

  logic            w_wb_hits_issue;
  logic            w_issue_set_en;
  logic            w_wb_en;
  logic [NREG-1:0] w_issue_set;
  logic [NREG-1:0] w_wb_mask;
  logic [NREG-1:0] w_busy_next;

  assign w_wb_hits_issue = wb_valid & (wb_addr == issue_addr);
  assign issue_ready     = ~r_busy[issue_addr] | w_wb_hits_issue | (issue_addr == C_ZERO_ADDR);

  // The zero register is accepted on issue but never marked busy.
  assign w_issue_set_en = issue_valid & issue_ready & (issue_addr != C_ZERO_ADDR);
  assign w_wb_en        = wb_valid & (wb_addr != C_ZERO_ADDR);

  decoder_n #(.ADDR_W(ADDR_W)) u_issue_dec (
    .addr_in    (issue_addr),
    .enable     (w_issue_set_en),
    .onehot_out (w_issue_set)
  );

  decoder_n #(.ADDR_W(ADDR_W)) u_wb_dec (
    .addr_in    (wb_addr),
    .enable     (w_wb_en),
    .onehot_out (w_wb_mask)
  );

  // Set applied after clear so a same-cycle issue keeps the register busy.
  assign w_busy_next = (r_busy & ~w_wb_mask) | w_issue_set;

  // A same-cycle writeback resolves the hazard through forwarding.
  assign hazard_a = (rd_addr_a != C_ZERO_ADDR) & r_busy[rd_addr_a]
                  & ~(wb_valid & (wb_addr == rd_addr_a));
  assign hazard_b = (rd_addr_b != C_ZERO_ADDR) & r_busy[rd_addr_b]
                  & ~(wb_valid & (wb_addr == rd_addr_b));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy      <= '0;
      r_we_onehot <= '0;
      r_wb_orphan <= 1'b0;
    end else begin
      r_busy      <= w_busy_next;
      r_we_onehot <= w_wb_mask;
      r_wb_orphan <= w_wb_en & ~r_busy[wb_addr];
    end
  end

  assign busy      = r_busy;
  assign we_onehot = r_we_onehot;
  assign wb_orphan = r_wb_orphan;
endmodule

`default_nettype wire

// File: tb/tb_reg_write_scoreboard.sv
//------------------------------------------------------------------------------
// tb_reg_write_scoreboard
// Directed vector table, randomized model comparison and a 3-bit address build.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_reg_write_scoreboard;
  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, wb_valid;
  logic [4:0]  issue_addr, wb_addr, rd_addr_a, rd_addr_b;
  logic        issue_ready, hazard_a, hazard_b, wb_orphan;
  logic [31:0] we_onehot, busy;

  logic        reset3, wb_valid3;
  logic [2:0]  wb_addr3;
  logic        issue_ready3, hazard_a3, hazard_b3, wb_orphan3;
  logic [7:0]  we_onehot3, busy3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_write_scoreboard #(.ADDR_W(5), .ZERO_REG(31)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .hazard_a(hazard_a), .hazard_b(hazard_b),
    .we_onehot(we_onehot), .busy(busy), .wb_orphan(wb_orphan)
  );

  reg_write_scoreboard #(.ADDR_W(3), .ZERO_REG(7)) dut3 (
    .clk(clk), .reset(reset3),
    .issue_valid(1'b0), .issue_addr(3'd0), .issue_ready(issue_ready3),
    .wb_valid(wb_valid3), .wb_addr(wb_addr3),
    .rd_addr_a(3'd0), .rd_addr_b(3'd0),
    .hazard_a(hazard_a3), .hazard_b(hazard_b3),
    .we_onehot(we_onehot3), .busy(busy3), .wb_orphan(wb_orphan3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, iv;
    logic [4:0]  ia;
    logic        wv;
    logic [4:0]  wa, ra, rb;
    logic        ready, ha, hb;
    logic [31:0] busy, we;
    logic        orph;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic iv, input int ia, input logic wv, input int wa,
                     input int ra, input int rb, input logic rdy, input logic ha, input logic hb,
                     input logic [31:0] bz, input logic [31:0] we, input logic orph);
    vec_t v;
    v.rst = rst; v.iv = iv; v.ia = 5'(ia); v.wv = wv; v.wa = 5'(wa);
    v.ra = 5'(ra); v.rb = 5'(rb); v.ready = rdy; v.ha = ha; v.hb = hb;
    v.busy = bz; v.we = we; v.orph = orph;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic iv, input logic [4:0] ia, input logic wv,
                       input logic [4:0] wa, input logic [4:0] ra, input logic [4:0] rb);
    reset = rst; issue_valid = iv; issue_addr = ia; wb_valid = wv; wb_addr = wa;
    rd_addr_a = ra; rd_addr_b = rb;
  endtask

  // Reference state: one bit per register, updated from the rules directly.
  bit mbusy[32];

  initial begin
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    reset3 = 1'b1; wb_valid3 = 1'b0; wb_addr3 = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 32'h0);
    chk("reset_we", we_onehot, 32'h0);
    chk("reset_orphan", {31'b0, wb_orphan}, 32'h0);
    reset = 1'b0; reset3 = 1'b0;

    //   rst iv ia  wv wa  ra rb  rdy ha hb  busy         we           orph
    add(0, 0, 0,  1, 5,  0, 0,  1, 0, 0, 32'h0,       32'h20,      1);
    add(0, 1, 3,  0, 0,  3, 0,  1, 0, 0, 32'h8,       32'h0,       0);
    add(0, 0, 0,  0, 0,  3, 0,  1, 1, 0, 32'h8,       32'h0,       0);
    add(0, 0, 0,  1, 3,  3, 0,  1, 0, 0, 32'h0,       32'h8,       0);
    add(0, 1, 7,  0, 0,  0, 0,  1, 0, 0, 32'h80,      32'h0,       0);
    add(0, 1, 7,  0, 0,  0, 7,  0, 0, 1, 32'h80,      32'h0,       0);
    add(0, 1, 7,  1, 7,  7, 0,  1, 0, 0, 32'h80,      32'h80,      0);
    add(0, 1, 31, 1, 31, 0, 31, 1, 0, 0, 32'h80,      32'h0,       0);
    add(0, 0, 0,  1, 7,  0, 0,  1, 0, 0, 32'h0,       32'h80,      0);
    add(0, 1, 1,  0, 0,  0, 0,  1, 0, 0, 32'h2,       32'h0,       0);
    add(0, 1, 2,  0, 0,  0, 0,  1, 0, 0, 32'h6,       32'h0,       0);
    add(0, 1, 4,  0, 0,  0, 0,  1, 0, 0, 32'h16,      32'h0,       0);
    add(1, 1, 8,  1, 1,  2, 4,  1, 1, 1, 32'h0,       32'h0,       0);
    add(0, 0, 0,  0, 0,  2, 4,  1, 0, 0, 32'h0,       32'h0,       0);
    add(0, 1, 9,  0, 0,  0, 0,  1, 0, 0, 32'h200,     32'h0,       0);
    add(0, 0, 0,  1, 9,  0, 0,  1, 0, 0, 32'h0,       32'h200,     0);
    add(0, 1, 9,  0, 0,  0, 0,  1, 0, 0, 32'h200,     32'h0,       0);
    add(0, 0, 0,  1, 9,  9, 0,  1, 0, 0, 32'h0,       32'h200,     0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].iv, tbl[i].ia, tbl[i].wv, tbl[i].wa, tbl[i].ra, tbl[i].rb);
      #1;
      chk($sformatf("vec%0d_ready", i), {31'b0, issue_ready}, {31'b0, tbl[i].ready});
      chk($sformatf("vec%0d_haz_a", i), {31'b0, hazard_a}, {31'b0, tbl[i].ha});
      chk($sformatf("vec%0d_haz_b", i), {31'b0, hazard_b}, {31'b0, tbl[i].hb});
      @(posedge clk); #1;
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("vec%0d_we", i), we_onehot, tbl[i].we);
      chk($sformatf("vec%0d_orphan", i), {31'b0, wb_orphan}, {31'b0, tbl[i].orph});
    end

    // Randomized run; addresses drawn from a small pool plus the zero register to force collisions.
    for (int r = 0; r < 32; r++) mbusy[r] = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic        rst, iv, wv, e_rdy, e_ha, e_hb, e_orph;
      int          ia, wa, ra, rb, k;
      logic [31:0] e_we, e_busy;
      rst = ($urandom_range(0, 39) == 0);
      iv  = $urandom_range(0, 1);
      wv  = $urandom_range(0, 1);
      k = $urandom_range(0, 8); ia = (k == 8) ? 31 : k;
      k = $urandom_range(0, 8); wa = (k == 8) ? 31 : k;
      k = $urandom_range(0, 8); ra = (k == 8) ? 31 : k;
      k = $urandom_range(0, 8); rb = (k == 8) ? 31 : k;
      drive(rst, iv, 5'(ia), wv, 5'(wa), 5'(ra), 5'(rb));

      e_rdy  = !mbusy[ia] || (wv && wa == ia) || ia == 31;
      e_ha   = (ra != 31) && mbusy[ra] && !(wv && wa == ra);
      e_hb   = (rb != 31) && mbusy[rb] && !(wv && wa == rb);
      e_we   = (wv && wa != 31) ? (32'h1 << wa) : 32'h0;
      e_orph = wv && wa != 31 && !mbusy[wa];
      if (rst) begin
        for (int r = 0; r < 32; r++) mbusy[r] = 1'b0;
        e_we = 32'h0; e_orph = 1'b0;
      end else begin
        if (wv && wa != 31) mbusy[wa] = 1'b0;
        if (iv && e_rdy && ia != 31) mbusy[ia] = 1'b1;
      end
      e_busy = 32'h0;
      for (int r = 0; r < 32; r++) if (mbusy[r]) e_busy = e_busy | (32'h1 << r);

      #1;
      chk($sformatf("rnd%0d_ready", n), {31'b0, issue_ready}, {31'b0, e_rdy});
      chk($sformatf("rnd%0d_haz_a", n), {31'b0, hazard_a}, {31'b0, e_ha});
      chk($sformatf("rnd%0d_haz_b", n), {31'b0, hazard_b}, {31'b0, e_hb});
      @(posedge clk); #1;
      chk($sformatf("rnd%0d_busy", n), busy, e_busy);
      chk($sformatf("rnd%0d_we", n), we_onehot, e_we);
      chk($sformatf("rnd%0d_orphan", n), {31'b0, wb_orphan}, {31'b0, e_orph});
    end
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0);

    // Narrow build: every writeback address, zero register last.
    for (int a = 0; a < 8; a++) begin
      wb_valid3 = 1'b1; wb_addr3 = 3'(a);
      @(posedge clk); #1;
      chk($sformatf("aw3_we_%0d", a), {24'b0, we_onehot3}, (a == 7) ? 32'h0 : (32'h1 << a));
      chk($sformatf("aw3_orphan_%0d", a), {31'b0, wb_orphan3}, (a == 7) ? 32'h0 : 32'h1);
      chk($sformatf("aw3_busy_%0d", a), {24'b0, busy3}, 32'h0);
    end
    wb_valid3 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/reg_write_scoreboard.md
# reg_write_scoreboard

Parametrised register-writeback decoder with a pending-write scoreboard for the 5-stage pipeline. It decodes the writeback destination address into a registered one-hot register-file write-enable vector, never enabling the hard-wired zero register. It also tracks which registers have an in-flight write between issue (decode stage) and writeback, so the hazard unit can stall dependent reads. It sits between the decode/hazard logic and the register file write port.

## Interface
Parameters:
- ADDR_W, 5, register address width; NREG = 2**ADDR_W registers
- ZERO_REG, 31, index of the hard-wired zero register; never enabled, never busy

Ports (clock and reset first):
- clk  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high reset
- issue_valid  in  1  an instruction with a register destination issues this cycle
- issue_addr  in  ADDR_W  destination of the issuing instruction
- issue_ready  out  1  issue is accepted this cycle (combinational)
- wb_valid  in  1  writeback occurs this cycle
- wb_addr  in  ADDR_W  writeback destination
- rd_addr_a, rd_addr_b  in  ADDR_W  source registers of the instruction in decode
- hazard_a, hazard_b  out  1  source has an unresolved pending write (combinational)
- we_onehot  out  NREG  registered one-hot register-file write enables
- busy  out  NREG  registered pending-write mask
- wb_orphan  out  1  registered pulse: writeback hit a register that was not busy

## Operation
- Clock and reset: one clock; reset is synchronous and active-high (ports clk, reset).
- busy[r] set on accepted issue to r; cleared on wb to r; issue and wb to the same r in one cycle leave busy[r]=1 (issue wins).
- issue_ready = !busy[issue_addr] | (wb_valid & wb_addr==issue_addr) | issue_addr==ZERO_REG.
- Issue with issue_ready=0 is ignored (busy unchanged); the hazard unit must hold it.
- Issue to ZERO_REG: accepted, busy unchanged.
- hazard_x = busy[rd_addr_x] & !(wb_valid & wb_addr==rd_addr_x); forced 0 when rd_addr_x==ZERO_REG. Same-cycle writeback counts as resolved (forwarding covers it).
- we_onehot: exactly one bit high, index wb_addr, for one cycle after each wb_valid; all zero if wb_addr==ZERO_REG or wb_valid=0.
- wb_orphan: high for one cycle after a wb_valid to a non-zero register whose busy bit was 0; we_onehot still fires.
- Widths: all address compares are ADDR_W bits exact; no wrap-around, since NREG covers the full address space.

## Timing
- Reset values: busy=0, we_onehot=0, wb_orphan=0. Reset overrides simultaneous issue/wb in that cycle.
- Reset mid-operation: all pending writes are discarded and the next cycle reports no hazards.
- busy and we_onehot latency: 1 cycle from the input edge.
- issue_ready and hazard_a/b: 0-cycle combinational from inputs and current busy.
- Back-to-back: wb to r in cycle n, then issue to r in cycle n+1, is accepted (busy[r]=0 at n+1).

## Structure
- Package reg_write_pkg: ADDR_W default, NREG constant, ZERO_REG default, addr_t typedef.
- Sub-module decoder_n (parameter ADDR_W; in, enable -> one-hot NREG out). It is the generalised successor of the fixed 3-to-8 decoder and is instantiated for the issue set-mask and the wb clear/we masks.
- Top module: busy register, we_onehot/wb_orphan registers, and the ready/hazard comparison logic.

## Test plan
- Reset, then wb_valid=1 wb_addr=5: we_onehot=0x0000_0020 the next cycle, wb_orphan=1, busy=0.
- Issue addr 3; next cycle rd_addr_a=3 gives hazard_a=1. wb addr 3 that cycle gives hazard_a=0 combinationally; the following cycle busy[3]=0 and we_onehot bit 3=1.
- busy[7]=1; issue 7 with no wb gives issue_ready=0 and busy unchanged. Issue 7 together with wb 7 gives issue_ready=1 and busy[7] stays 1.
- ZERO_REG: issue 31 and wb 31 give issue_ready=1, busy[31]=0, we_onehot=0, wb_orphan=0; rd_addr_b=31 gives hazard_b=0.
- Issue 1, 2, 4 on consecutive cycles (busy=0x16), then reset=1 with issue 8: next cycle busy=0 and all outputs 0.
- ADDR_W=3 build: exhaustive wb over 0..7 with ZERO_REG=7 gives one-hot bits 0..6 and 0 for address 7.
